load_store_unit: RTL

Memory-access stage sitting directly upstream of the word-wide data memory. It takes one load/store request at a time from the MEM pipeline stage and converts it into word-address memory strobes. Sub-word stores (SB/SH) are done as read-modify-write because the memory has no byte enables. Load data is aligned and sign- or zero-extended for writeback, and misaligned, out-of-range and illegal accesses are reported instead of being issued.

---
 rtl/load_store_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store stage in front of a word-wide memory without byte enables.
// Sub-word stores go through read-modify-write; loads are aligned and extended here.
module load_store_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_we,
  input  logic [2:0]       i_req_funct3,
  input  logic [WIDTH-1:0] i_req_addr,
  input  logic [WIDTH-1:0] i_req_wdata,
  output logic             o_resp_valid,
  output logic [WIDTH-1:0] o_resp_rdata,
  output logic             o_resp_misaligned,
  output logic             o_resp_fault,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  input  logic [WIDTH-1:0] i_mem_rdata
);
  localparam int NBYTES = WIDTH / 8;
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(DEPTH * 4);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_FMT, S_MERGE, S_WR, S_DONE} state_t;
  state_t r_state, w_next;

  logic [2:0]       r_f3;
  logic [1:0]       r_off;
  logic             r_we;
  logic [15:0]      r_wdata;
  logic             r_mis, r_fault;
  logic [WIDTH-1:0] r_rdata, r_addr, r_mem_wdata;

  logic w_accept, w_legal, w_mis, w_oor, w_err;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [WIDTH-1:0] w_fmt, w_merge;

  assign w_accept = i_req_valid && (r_state == S_IDLE);
  assign w_legal  = i_req_we ? (i_req_funct3 inside {3'b000, 3'b001, 3'b010})
                             : (i_req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign w_mis    = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                    ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
  assign w_oor    = i_req_addr >= LIMIT;
  assign w_err    = !w_legal || w_mis || w_oor;

  // Load formatting: lane pick from the word read back, then extend by funct3.
  assign w_byte = i_mem_rdata[{r_off, 3'b000} +: 8];
  assign w_half = i_mem_rdata[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    w_fmt = i_mem_rdata;
    case (r_f3)
      3'b000:  w_fmt = {{(WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_fmt = {{(WIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_fmt = {{(WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_fmt = {{(WIDTH-16){1'b0}}, w_half};
      default: w_fmt = i_mem_rdata;
    endcase
  end

  // Store merge: SB hits the one lane at the offset, SH hits both lanes of the half.
  for (genvar i = 0; i < NBYTES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    logic w_hit;
    assign w_hit = r_f3[0] ? (r_off[1] == LANE[1]) : (r_off == LANE);
    assign w_merge[8*i +: 8] = !w_hit ? i_mem_rdata[8*i +: 8]
                             : (r_f3[0] ? r_wdata[8*(i%2) +: 8] : r_wdata[7:0]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_req_valid) begin
                 if (w_err)                               w_next = S_DONE;
                 else if (i_req_we && i_req_funct3[1])    w_next = S_WR;
                 else                                     w_next = S_RD;
               end
      S_RD:    w_next = r_we ? S_MERGE : S_FMT;
      S_FMT:   w_next = S_DONE;
      S_MERGE: w_next = S_WR;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_f3        <= '0;
      r_off       <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_mis       <= 1'b0;
      r_fault     <= 1'b0;
      r_rdata     <= '0;
      r_addr      <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_accept) begin
        r_f3    <= i_req_funct3;
        r_off   <= i_req_addr[1:0];
        r_we    <= i_req_we;
        r_wdata <= i_req_wdata[15:0];
        r_mis   <= w_legal && w_mis;
        r_fault <= !w_legal || (!w_mis && w_oor);
        r_rdata <= '0;
        // Errored requests never reach memory, so the strobe bus keeps its last value.
        if (!w_err) begin
          r_addr <= {2'b00, i_req_addr[WIDTH-1:2]};
          if (i_req_we && i_req_funct3[1]) r_mem_wdata <= i_req_wdata;
        end
      end
      if (r_state == S_FMT)   r_rdata     <= w_fmt;
      if (r_state == S_MERGE) r_mem_wdata <= w_merge;
    end
  end

  assign o_req_ready       = (r_state == S_IDLE);
  assign o_mem_read        = (r_state == S_RD);
  assign o_mem_write       = (r_state == S_WR);
  assign o_resp_valid      = (r_state == S_DONE);
  assign o_resp_misaligned = o_resp_valid && r_mis;
  assign o_resp_fault      = o_resp_valid && r_fault;
  assign o_resp_rdata      = r_rdata;
  assign o_mem_addr        = r_addr;
  assign o_mem_wdata       = r_mem_wdata;
endmodule
